// File: rtl/msg_fifo_arbiter.sv
// Round-robin arbiter that writes one 3-word bounding-box message at a time into the CPU message FIFO.
// A message is dropped when the FIFO lacks room for all three words, or when a flush interrupts it.
module msg_fifo_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 256,
  parameter int USEDW_W    = 8,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_id,
  input  logic [32*NUM_REQ-1:0]  req_tl,
  input  logic [32*NUM_REQ-1:0]  req_br,
  output logic [NUM_REQ-1:0]     req_grant,
  output logic [NUM_REQ-1:0]     req_drop,
  output logic [31:0]            fifo_data,
  output logic                   fifo_wr,
  input  logic [USEDW_W-1:0]     fifo_usedw,
  input  logic                   fifo_flush,
  output logic                   busy,
  output logic [CNT_W-1:0]       drop_count
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [USEDW_W:0] ROOM_MAX = (USEDW_W+1)'(FIFO_DEPTH - 4);

  typedef enum logic [1:0] {IDLE, W0, W1, W2} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0]   sel_reg, sel_next;
  logic [31:0]        id_reg, id_next, tl_reg, tl_next, br_reg, br_next;
  logic [CNT_W-1:0]   drop_count_reg, drop_count_next, drop_inc;
  logic [NUM_REQ-1:0] blocked_reg, eligible;

  logic [31:0] id_word [NUM_REQ];
  logic [31:0] tl_word [NUM_REQ];
  logic [31:0] br_word [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_words
      assign id_word[gi] = req_id[32*gi +: 32];
      assign tl_word[gi] = req_tl[32*gi +: 32];
      assign br_word[gi] = req_br[32*gi +: 32];
    end
  endgenerate

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] k);
    if (k == IDX_W'(NUM_REQ - 1)) return '0;
    return k + 1'b1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] k);
    return NUM_REQ'(1) << k;
  endfunction

  // A requester just granted or dropped is masked for one cycle so its stale request is not re-taken.
  assign eligible = req_valid & ~blocked_reg;
  assign drop_inc = (drop_count_reg == '1) ? drop_count_reg : drop_count_reg + 1'b1;

  logic             found, room;
  logic [IDX_W-1:0] pick;
  logic [IDX_W:0]   probe;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    probe = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      probe = {1'b0, rr_ptr_reg} + (IDX_W+1)'(i);
      if (probe >= (IDX_W+1)'(NUM_REQ)) probe = probe - (IDX_W+1)'(NUM_REQ);
      if (!found && eligible[probe[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = probe[IDX_W-1:0];
      end
    end
  end

  assign room = ({1'b0, fifo_usedw} <= ROOM_MAX);

  always_comb begin
    state_next      = state_reg;
    rr_ptr_next     = rr_ptr_reg;
    sel_next        = sel_reg;
    id_next         = id_reg;
    tl_next         = tl_reg;
    br_next         = br_reg;
    drop_count_next = drop_count_reg;
    req_grant       = '0;
    req_drop        = '0;
    fifo_wr         = 1'b0;
    fifo_data       = '0;
    case (state_reg)
      IDLE: begin
        if (enable && !fifo_flush && found) begin
          if (room) begin
            id_next    = id_word[pick];
            tl_next    = tl_word[pick];
            br_next    = br_word[pick];
            sel_next   = pick;
            state_next = W0;
          end else begin
            req_drop        = onehot(pick);
            drop_count_next = drop_inc;
            rr_ptr_next     = next_idx(pick);
          end
        end
      end
      default: begin
        if (fifo_flush) begin
          // A flushed partial message is abandoned, never resumed.
          req_drop        = onehot(sel_reg);
          drop_count_next = drop_inc;
          rr_ptr_next     = next_idx(sel_reg);
          state_next      = IDLE;
        end else begin
          fifo_wr = 1'b1;
          case (state_reg)
            W0:      begin fifo_data = id_reg; state_next = W1; end
            W1:      begin fifo_data = tl_reg; state_next = W2; end
            default: begin
              fifo_data   = br_reg;
              req_grant   = onehot(sel_reg);
              rr_ptr_next = next_idx(sel_reg);
              state_next  = IDLE;
            end
          endcase
        end
      end
    endcase
    if (reset) begin
      req_grant = '0;
      req_drop  = '0;
      fifo_wr   = 1'b0;
      fifo_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      sel_reg        <= '0;
      id_reg         <= '0;
      tl_reg         <= '0;
      br_reg         <= '0;
      drop_count_reg <= '0;
      blocked_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      rr_ptr_reg     <= rr_ptr_next;
      sel_reg        <= sel_next;
      id_reg         <= id_next;
      tl_reg         <= tl_next;
      br_reg         <= br_next;
      drop_count_reg <= drop_count_next;
      blocked_reg    <= req_grant | req_drop;
    end
  end

  assign busy       = (state_reg != IDLE);
  assign drop_count = drop_count_reg;

endmodule
